padc_dig_ctrl: RTL

PADC_DIG_CTRL -- requirements
Module: padc_dig_ctrl

---
 rtl/padc_dig_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/padc_dig_ctrl.sv
// Digital back end of a 7-stage pipelined ADC: stage alignment, redundancy correction
// and a show-ahead output FIFO. Optional macro PADC_DIG_CTRL_OVF_CNT_EN adds the drop counter.
`timescale 1ns/1ps
module padc_dig_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int OVF_W      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [1:0]       dig_raw [7],
    input  logic             out_ready,
    output logic             out_valid,
    output logic [7:0]       out_code,
    output logic             busy,
    output logic             code_err,
    output logic [OVF_W-1:0] ovf_cnt
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [2:0]        fill_cnt_r;
    logic              busy_r;
    logic              flush_s;
    logic              tag_in_s;
    logic [5:0]        tag_r;
    logic [6:0][1:0]   aligned_s;
    logic [7:0]        sum_s;
    logic              err_s;
    logic [7:0]        code_r;
    logic              code_vld_r;
    logic              code_err_r;
    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [AW:0]       wr_ptr_nxt_s;
    logic [AW:0]       rd_ptr_nxt_s;
    logic              full_s;
    logic              pop_s;
    logic              wr_req_s;
    logic              push_s;
    logic [7:0]        head_nxt_s;
    logic              out_valid_r;
    logic [7:0]        out_code_r;

    // An illegal 2'b11 decision is weighted as 2'b10
    function automatic logic [1:0] fix_code(input logic [1:0] d);
        fix_code = (d == 2'b11) ? 2'b10 : d;
    endfunction

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) state_nxt_s = FILL;
                else    state_nxt_s = IDLE;
            end
            FILL: begin
                if (!en)                     state_nxt_s = IDLE;
                else if (fill_cnt_r == 3'd6) state_nxt_s = RUN;
                else                         state_nxt_s = FILL;
            end
            RUN: begin
                if (!en) state_nxt_s = DRAIN;
                else     state_nxt_s = RUN;
            end
            DRAIN: begin
                if (en)               state_nxt_s = FILL;
                else if (!out_valid_r) state_nxt_s = IDLE;
                else                  state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    assign flush_s  = (state_r == FILL) && !en;
    // A sample is kept only if its stage-0 code is taken while entering or staying in RUN
    assign tag_in_s = (state_nxt_s == RUN);

    // State register, FILL cycle counter and busy flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            fill_cnt_r <= 3'd0;
            busy_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            if ((state_r == FILL) && (state_nxt_s == FILL)) fill_cnt_r <= fill_cnt_r + 3'd1;
            else                                            fill_cnt_r <= 3'd0;
        end
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_dly
        logic [1:0] dly_r [6-gi];
        // Delay line holding stage gi until the later stages of its sample arrive
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int k = 0; k < 6 - gi; k++) dly_r[k] <= 2'b00;
            end else if (flush_s) begin
                for (int k = 0; k < 6 - gi; k++) dly_r[k] <= 2'b00;
            end else begin
                dly_r[0] <= dig_raw[gi];
                for (int k = 1; k < 6 - gi; k++) dly_r[k] <= dly_r[k-1];
            end
        end
        assign aligned_s[gi] = dly_r[5-gi];
    end
    assign aligned_s[6] = dig_raw[6];

    // Redundancy correction: weighted sum of the coincident stage codes
    always_comb begin
        sum_s = 8'd0;
        err_s = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sum_s = sum_s + ({6'd0, fix_code(aligned_s[i])} << (6 - i));
            err_s = err_s | (aligned_s[i] == 2'b11);
        end
    end

    // Sample tag pipeline, corrected-word register and sticky illegal-code flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_r      <= 6'd0;
            code_vld_r <= 1'b0;
            code_r     <= 8'd0;
            code_err_r <= 1'b0;
        end else begin
            if (flush_s) begin
                tag_r      <= 6'd0;
                code_vld_r <= 1'b0;
            end else begin
                tag_r      <= {tag_r[4:0], tag_in_s};
                code_vld_r <= tag_r[5];
            end
            code_r <= sum_s;
            if (tag_r[5] && err_s) code_err_r <= 1'b1;
            else                   code_err_r <= code_err_r;
        end
    end

    assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s    = out_valid_r && out_ready;
    assign wr_req_s = code_vld_r && (state_r == RUN);
    assign push_s   = wr_req_s && (!full_s || pop_s);

    // Pointer advance and the head word seen after this edge
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        head_nxt_s   = 8'd0;
        if (push_s) wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        else        wr_ptr_nxt_s = wr_ptr_r;
        if (pop_s)  rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        else        rd_ptr_nxt_s = rd_ptr_r;
        // A word pushed into an otherwise empty FIFO becomes the head directly
        if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) head_nxt_s = code_r;
        else                                      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end

    // FIFO storage, pointers and registered show-ahead outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r    <= {(AW+1){1'b0}};
            rd_ptr_r    <= {(AW+1){1'b0}};
            out_valid_r <= 1'b0;
            out_code_r  <= 8'd0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem_r[k] <= 8'd0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            out_valid_r <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
            out_code_r  <= head_nxt_s;
            if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= code_r;
        end
    end

`ifdef PADC_DIG_CTRL_OVF_CNT_EN
    logic [OVF_W-1:0] ovf_cnt_r;
    logic             drop_s;

    assign drop_s = wr_req_s && full_s && !pop_s;

    // Saturating count of words dropped on a full FIFO
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_cnt_r <= {OVF_W{1'b0}};
        end else if (drop_s && (ovf_cnt_r != {OVF_W{1'b1}})) begin
            ovf_cnt_r <= ovf_cnt_r + OVF_W'(1);
        end else begin
            ovf_cnt_r <= ovf_cnt_r;
        end
    end

    assign ovf_cnt = ovf_cnt_r;
`else
    assign ovf_cnt = {OVF_W{1'b0}};
`endif

    assign out_valid = out_valid_r;
    assign out_code  = out_code_r;
    assign busy      = busy_r;
    assign code_err  = code_err_r;

endmodule
